obi_rr_arbiter: RTL and testbench

Parametrised N-master to 1-slave OBI arbiter placed between the cv32e40p instruction/data ports (plus any extra masters, e.g. DMA or debug) and a single bus slave port. Arbitrates address phases round-robin, holds a locked selection while a request waits for grant, and tracks up to DEPTH outstanding transactions in an ID FIFO so each response is routed back to the master that issued it. Adds zero cycles of latency in either direction.

---
 rtl/obi_rr_arbiter.sv | 134 +++++++++++++
 tb/tb_obi_rr_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/obi_rr_arbiter.sv
// N-master to 1-slave OBI arbiter: round-robin address-phase arbitration with
// a grant-wait lock, plus an ID FIFO that routes each response back to the
// master that issued the request. Zero added latency in both directions.
module obi_rr_arbiter #(
    parameter int N_MASTERS = 2,
    parameter int DEPTH     = 4,
    parameter int AW        = 32,
    parameter int DW        = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_MASTERS-1:0]      m_req,
    input  logic [N_MASTERS-1:0]      m_we,
    input  logic [N_MASTERS*DW/8-1:0] m_be,
    input  logic [N_MASTERS*AW-1:0]   m_addr,
    input  logic [N_MASTERS*DW-1:0]   m_wdata,
    output logic [N_MASTERS-1:0]      m_gnt,
    output logic [N_MASTERS-1:0]      m_rvalid,
    output logic [DW-1:0]             m_rdata,
    output logic                      s_req,
    output logic                      s_we,
    output logic [DW/8-1:0]           s_be,
    output logic [AW-1:0]             s_addr,
    output logic [DW-1:0]             s_wdata,
    input  logic                      s_gnt,
    input  logic                      s_rvalid,
    input  logic [DW-1:0]             s_rdata,
    output logic                      err
);
    localparam int BW = DW / 8;
    localparam int IW = $clog2(N_MASTERS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          lock_q, lock_d;
    logic [IW-1:0] lock_id_q, lock_id_d;
    logic [IW-1:0] fifo_q [DEPTH];
    logic [IW-1:0] fifo_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [IW-1:0] rr_sel, sel;
    logic          full, hs, pop;

    // Round-robin scan starting at rr_ptr; a stalled request keeps its master.
    always_comb begin
        int  idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        rr_sel = rr_ptr_q;
        for (int k = 0; k < N_MASTERS; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_MASTERS;
            if (!found && m_req[idx]) begin
                found  = 1'b1;
                rr_sel = IW'(idx);
            end
        end
        sel = lock_q ? lock_id_q : rr_sel;
    end

    // Request/response paths are purely combinational.
    always_comb begin
        full     = (cnt_q == CW'(DEPTH));
        s_req    = m_req[sel] & ~full & ~rst;
        s_we     = m_we[sel];
        s_be     = m_be[int'(sel)*BW +: BW];
        s_addr   = m_addr[int'(sel)*AW +: AW];
        s_wdata  = m_wdata[int'(sel)*DW +: DW];
        hs       = s_req & s_gnt;
        m_gnt    = '0;
        if (hs) m_gnt[sel] = 1'b1;
        // The head is always valid here: OBI never answers in the grant cycle.
        pop      = s_rvalid & (cnt_q != '0) & ~rst;
        m_rvalid = '0;
        if (pop) m_rvalid[fifo_q[rd_ptr_q]] = 1'b1;
        m_rdata  = s_rdata;
        err      = err_q;
    end

    // Next-state: pointer rotation, lock, ID FIFO and sticky error.
    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        fifo_d    = fifo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        if (hs) begin
            fifo_d[wr_ptr_q] = sel;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            rr_ptr_d         = (sel == IW'(N_MASTERS - 1)) ? '0 : sel + 1'b1;
            lock_d           = 1'b0;
        end else if (s_req) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (s_rvalid && cnt_q == '0) err_d = 1'b1;
    end

    // State register with synchronous reset; reset drops all outstanding IDs.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end
endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed bench for obi_rr_arbiter (N_MASTERS=2, DEPTH=2): one vector per
// clock cycle, plus a hand-written back-to-back alternation sequence.
module tb_obi_rr_arbiter;
    localparam int N = 2, D = 2, AW = 32, DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      m_req, m_we, m_gnt, m_rvalid;
    logic [N*DW/8-1:0] m_be;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [DW-1:0]     m_rdata, s_wdata, s_rdata;
    logic              s_req, s_we, s_gnt, s_rvalid, err;
    logic [DW/8-1:0]   s_be;
    logic [AW-1:0]     s_addr;

    obi_rr_arbiter #(.N_MASTERS(N), .DEPTH(D), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_be(m_be),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .s_req(s_req), .s_we(s_we), .s_be(s_be),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_gnt(s_gnt), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_sreq;
        logic [1:0]  e_gnt;
        logic [1:0]  e_rv;
        logic        e_msel;
        logic        e_err;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   failures = 0;

    logic [AW-1:0]   addr_of  [N] = '{32'h0000_0100, 32'h0000_0200};
    logic [DW-1:0]   wdata_of [N] = '{32'hAAAA_0000, 32'hBBBB_0001};
    logic [DW/8-1:0] be_of    [N] = '{4'h3, 4'hC};
    logic            we_of    [N] = '{1'b0, 1'b1};

    function automatic vec_t v(logic r, logic [1:0] q, logic g, logic rv,
                               logic [31:0] rd, logic es, logic [1:0] eg,
                               logic [1:0] erv, logic ms, logic ee);
        vec_t t;
        t.rst = r; t.req = q; t.gnt = g; t.rv = rv; t.rdata = rd;
        t.e_sreq = es; t.e_gnt = eg; t.e_rv = erv; t.e_msel = ms; t.e_err = ee;
        return t;
    endfunction

    task automatic chk(string name, int idx, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    task automatic apply_check(int idx, vec_t t);
        @(negedge clk);
        rst = t.rst; m_req = t.req; s_gnt = t.gnt; s_rvalid = t.rv; s_rdata = t.rdata;
        #1;
        chk("s_req", idx, 64'(s_req), 64'(t.e_sreq));
        chk("m_gnt", idx, 64'(m_gnt), 64'(t.e_gnt));
        chk("m_rvalid", idx, 64'(m_rvalid), 64'(t.e_rv));
        chk("err", idx, 64'(err), 64'(t.e_err));
        chk("m_rdata", idx, 64'(m_rdata), 64'(t.rdata));
        if (t.e_sreq) begin
            chk("s_addr", idx, 64'(s_addr), 64'(addr_of[t.e_msel]));
            chk("s_fields", idx, {31'd0, s_we, s_be, s_wdata},
                {31'd0, we_of[t.e_msel], be_of[t.e_msel], wdata_of[t.e_msel]});
        end
    endtask

    initial begin
        rst = 1'b1; m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        m_addr  = {addr_of[1], addr_of[0]};
        m_wdata = {wdata_of[1], wdata_of[0]};
        m_be    = {be_of[1], be_of[0]};
        m_we    = {we_of[1], we_of[0]};

        //             rst req   gnt rv  rdata           sreq gnt   rv   msel err
        // reset state, then single-master read
        vq.push_back(v(1, 2'b01, 1, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));
        vq.push_back(v(0, 2'b01, 1, 0, 32'h0,          1, 2'b01, 2'b00, 0, 0));
        vq.push_back(v(0, 2'b00, 0, 1, 32'hDEADBEEF,   0, 2'b00, 2'b01, 0, 0));
        // contention: rr_ptr=1 so master 1 first, then alternate
        vq.push_back(v(0, 2'b11, 1, 0, 32'h0,          1, 2'b10, 2'b00, 1, 0));
        vq.push_back(v(0, 2'b11, 1, 1, 32'h1111_0001,  1, 2'b01, 2'b10, 0, 0));
        vq.push_back(v(0, 2'b11, 1, 1, 32'h1111_0002,  1, 2'b10, 2'b01, 1, 0));
        vq.push_back(v(0, 2'b11, 1, 1, 32'h1111_0003,  1, 2'b01, 2'b10, 0, 0));
        vq.push_back(v(0, 2'b00, 0, 1, 32'h1111_0004,  0, 2'b00, 2'b01, 0, 0));
        // lock: master 0 stalls 3 cycles, master 1 (higher priority) joins
        vq.push_back(v(0, 2'b01, 0, 0, 32'h0,          1, 2'b00, 2'b00, 0, 0));
        vq.push_back(v(0, 2'b11, 0, 0, 32'h0,          1, 2'b00, 2'b00, 0, 0));
        vq.push_back(v(0, 2'b11, 0, 0, 32'h0,          1, 2'b00, 2'b00, 0, 0));
        vq.push_back(v(0, 2'b11, 1, 0, 32'h0,          1, 2'b01, 2'b00, 0, 0));
        vq.push_back(v(0, 2'b11, 1, 1, 32'h2222_0000,  1, 2'b10, 2'b01, 1, 0));
        // full: two outstanding, slave withholds rvalid
        vq.push_back(v(0, 2'b01, 1, 0, 32'h0,          1, 2'b01, 2'b00, 0, 0));
        vq.push_back(v(0, 2'b11, 1, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));
        vq.push_back(v(0, 2'b11, 1, 1, 32'h3333_0000,  0, 2'b00, 2'b10, 0, 0));
        vq.push_back(v(0, 2'b11, 1, 0, 32'h0,          1, 2'b10, 2'b00, 1, 0));
        vq.push_back(v(0, 2'b11, 0, 1, 32'h3333_0001,  0, 2'b00, 2'b01, 0, 0));
        vq.push_back(v(0, 2'b11, 1, 0, 32'h0,          1, 2'b01, 2'b00, 0, 0));
        // reset with two outstanding and rr_ptr=1; outputs gated while rst
        vq.push_back(v(1, 2'b11, 1, 1, 32'h4444_0000,  0, 2'b00, 2'b00, 0, 0));
        // after reset: rr_ptr=0, count=0, late rvalid is stray
        vq.push_back(v(0, 2'b11, 0, 1, 32'h4444_0001,  1, 2'b00, 2'b00, 0, 0));
        vq.push_back(v(0, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 1));
        vq.push_back(v(0, 2'b00, 0, 1, 32'h5555_0000,  0, 2'b00, 2'b00, 0, 1));
        vq.push_back(v(1, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 1));
        vq.push_back(v(0, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));

        foreach (vq[i]) apply_check(i, vq[i]);

        // Back-to-back: both masters request, slave grants every cycle and
        // answers one cycle later; grants alternate and responses follow them.
        begin
            logic [1:0] prev_gnt;
            logic [1:0] exp_gnt;
            prev_gnt = 2'b00;
            for (int k = 0; k < 9; k++) begin
                @(negedge clk);
                rst = 1'b0; m_req = (k < 8) ? 2'b11 : 2'b00;
                s_gnt = 1'b1; s_rvalid = (k > 0); s_rdata = 32'hC0DE_0000 + k;
                #1;
                exp_gnt = (k >= 8) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10);
                chk("rr_gnt", 100 + k, 64'(m_gnt), 64'(exp_gnt));
                chk("rr_rvalid", 100 + k, 64'(m_rvalid), 64'(prev_gnt));
                prev_gnt = exp_gnt;
            end
            @(negedge clk);
            m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
            #1;
            chk("idle_err", 200, 64'(err), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
